// File: rtl/controller.sv
// Instruction-sequencing FSM: fetches through PC/IM/IR, decodes the 16-bit word
// and drives Moore controls for the data memory, register file and ALU.
module controller (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Instruction,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IM_re,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP   = 4'd3;
  localparam logic [3:0] S_LOAD_A = 4'd4;
  localparam logic [3:0] S_LOAD_B = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_ADD    = 4'd7;
  localparam logic [3:0] S_SUB    = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [3:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rq;
  logic [7:0] addr;

  assign op    = Instruction[15:12];
  assign ra    = Instruction[11:8];
  assign rb    = Instruction[7:4];
  assign rq    = Instruction[3:0];
  assign addr  = Instruction[7:0];
  assign State = state;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_INIT;
    case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        // Illegal opcodes fall through to NOOP.
        case (op)
          OP_NOOP:  state_next = S_NOOP;
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOAD_A;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end
      S_NOOP:   state_next = S_FETCH;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_ADD:    state_next = S_FETCH;
      S_SUB:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IM_re      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IM_re = 1'b1;
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // D_addr is held across both load cycles for the synchronous-read memory.
      S_LOAD_A: begin
        D_addr    = addr;
        RF_s      = 1'b1;
        RF_W_addr = ra;
      end
      S_LOAD_B: begin
        D_addr    = addr;
        RF_s      = 1'b1;
        RF_W_addr = ra;
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = addr;
        RF_Ra_addr = ra;
        D_wr       = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rq;
        ALU_s0     = 3'b001;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rq;
        ALU_s0     = 3'b010;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: walks each instruction class through its
// state sequence and compares the full output bundle every cycle.
module tb_controller;

  logic        Clk;
  logic        Reset;
  logic [15:0] Instruction;
  logic        PC_clr;
  logic        PC_up;
  logic        IM_re;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;

  int unsigned errors = 0;
  int unsigned checks = 0;

  controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Instruction(Instruction),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IM_re      (IM_re),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bundle layout: State, PC_clr, PC_up, IM_re, IR_ld, D_addr, D_wr, RF_s,
  // RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0.
  logic [33:0] outs;
  assign outs = {State, PC_clr, PC_up, IM_re, IR_ld, D_addr, D_wr, RF_s,
                 RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};

  function automatic logic [33:0] mk(
    input logic [3:0] st, input logic pc_clr, input logic pc_up,
    input logic im_re, input logic ir_ld, input logic [7:0] d_addr,
    input logic d_wr, input logic rf_s, input logic [3:0] w_addr,
    input logic w_en, input logic [3:0] ra, input logic [3:0] rb,
    input logic [2:0] alu);
    return {st, pc_clr, pc_up, im_re, ir_ld, d_addr, d_wr, rf_s,
            w_addr, w_en, ra, rb, alu};
  endfunction

  logic [33:0] e_init, e_fetch, e_decode;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [33:0] e;
    Reset = 1'b1;
    Instruction = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== e_init) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, outs, e_init);
      end
    end
    Reset = 1'b0;
    tick();
    e = e_fetch;
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", outs, e);
    end
  endtask

  task automatic test_add();
    logic [33:0] e;
    Instruction = 16'h3123;
    tick();
    checks++;
    if (outs !== e_decode) begin
      errors++;
      $display("FAIL add_decode: got %h expected %h", outs, e_decode);
    end
    tick();
    e = mk(4'd7, 0, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'b001);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL add_exec: got %h expected %h", outs, e);
    end
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL add_refetch: got %h expected %h", outs, e_fetch);
    end
  endtask

  task automatic test_load();
    logic [33:0] e;
    Instruction = 16'h2A5C;
    tick();
    checks++;
    if (outs !== e_decode) begin
      errors++;
      $display("FAIL load_decode: got %h expected %h", outs, e_decode);
    end
    tick();
    e = mk(4'd4, 0, 0, 0, 0, 8'h5C, 0, 1, 4'hA, 0, 4'h0, 4'h0, 3'b000);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL load_a: got %h expected %h", outs, e);
    end
    tick();
    e = mk(4'd5, 0, 0, 0, 0, 8'h5C, 0, 1, 4'hA, 1, 4'h0, 4'h0, 3'b000);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL load_b: got %h expected %h", outs, e);
    end
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL load_refetch: got %h expected %h", outs, e_fetch);
    end
  endtask

  task automatic test_store();
    logic [33:0] e;
    Instruction = 16'h1477;
    tick();
    checks++;
    if (outs !== e_decode) begin
      errors++;
      $display("FAIL store_decode: got %h expected %h", outs, e_decode);
    end
    tick();
    e = mk(4'd6, 0, 0, 0, 0, 8'h77, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'b000);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL store_exec: got %h expected %h", outs, e);
    end
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL store_refetch: got %h expected %h", outs, e_fetch);
    end
  endtask

  task automatic test_sub();
    logic [33:0] e;
    Instruction = 16'h4321;
    tick();
    checks++;
    if (outs !== e_decode) begin
      errors++;
      $display("FAIL sub_decode: got %h expected %h", outs, e_decode);
    end
    tick();
    e = mk(4'd8, 0, 0, 0, 0, 8'h00, 0, 0, 4'h1, 1, 4'h3, 4'h2, 3'b010);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL sub_exec: got %h expected %h", outs, e);
    end
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL sub_refetch: got %h expected %h", outs, e_fetch);
    end
  endtask

  task automatic test_noop_illegal();
    logic [15:0] words [3];
    logic [33:0] e;
    words[0] = 16'h0000;
    words[1] = 16'hF0FF;
    words[2] = 16'h6123;
    e = mk(4'd3, 0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      Instruction = words[i];
      tick();
      checks++;
      if (outs !== e_decode) begin
        errors++;
        $display("FAIL noop_decode[%h]: got %h expected %h", words[i], outs, e_decode);
      end
      tick();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL noop_exec[%h]: got %h expected %h", words[i], outs, e);
      end
      tick();
      checks++;
      if (outs !== e_fetch) begin
        errors++;
        $display("FAIL noop_refetch[%h]: got %h expected %h", words[i], outs, e_fetch);
      end
    end
  endtask

  task automatic test_halt();
    logic [33:0] e;
    Instruction = 16'h5000;
    tick();
    checks++;
    if (outs !== e_decode) begin
      errors++;
      $display("FAIL halt_decode: got %h expected %h", outs, e_decode);
    end
    e = mk(4'd9, 0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, outs, e);
      end
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (outs !== e_init) begin
      errors++;
      $display("FAIL halt_reset: got %h expected %h", outs, e_init);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL halt_restart: got %h expected %h", outs, e_fetch);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [33:0] e;
    Instruction = 16'h2A5C;
    tick();
    tick();
    e = mk(4'd4, 0, 0, 0, 0, 8'h5C, 0, 1, 4'hA, 0, 4'h0, 4'h0, 3'b000);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL midload_load_a: got %h expected %h", outs, e);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (outs !== e_init) begin
      errors++;
      $display("FAIL midload_reset: got %h expected %h", outs, e_init);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (outs !== e_fetch) begin
      errors++;
      $display("FAIL midload_restart: got %h expected %h", outs, e_fetch);
    end
  endtask

  initial begin
    e_init   = mk(4'd0, 1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    e_fetch  = mk(4'd1, 0, 1, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    e_decode = mk(4'd2, 0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    Reset = 1'b1;
    Instruction = 16'h0000;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_sub();
    test_noop_illegal();
    test_reset_mid_load();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
